// File: rtl/video_pkg.sv
// Shared video-plane types: burst geometry, fetch FSM states and the 22-bit
// byte-address type used on the video bus.
package video_pkg;

  localparam int unsigned VIDEO_BURST_WORDS = 4;

  typedef logic [21:0] video_addr_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BURST    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } vsr_fetch_state_e;

  // Burst pointer counts 8-byte bursts; the bus wants a byte address.
  function automatic video_addr_t burst_addr(input logic [18:0] ptr);
    return {ptr, 3'b000};
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with a registered head word that holds its last
// value when the FIFO runs empty; clear has priority over push and pop.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW:0]      count_r;
  logic [WIDTH-1:0] head_r;
  logic             valid_r;

  logic             pop_ok_s;
  logic             push_ok_s;
  logic [AW-1:0]    rd_next_s;
  logic [AW:0]      count_next_s;
  logic [WIDTH-1:0] head_next_s;

  // Next head: pushed word if it lands in an otherwise empty FIFO, else the stored successor.
  always_comb begin
    pop_ok_s     = pop && (count_r != '0);
    push_ok_s    = push && ((count_r != (AW+1)'(DEPTH)) || pop_ok_s);
    rd_next_s    = rd_ptr_r + AW'(pop_ok_s);
    count_next_s = count_r + (AW+1)'(push_ok_s) - (AW+1)'(pop_ok_s);
    if (count_next_s == '0) begin
      head_next_s = head_r;
    end else if ((count_r - (AW+1)'(pop_ok_s)) == '0) begin
      head_next_s = wdata;
    end else begin
      head_next_s = mem_r[rd_next_s];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      head_r   <= '0;
      valid_r  <= 1'b0;
    end else if (clear) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      valid_r  <= 1'b0;
    end else begin
      rd_ptr_r <= rd_next_s;
      wr_ptr_r <= wr_ptr_r + AW'(push_ok_s);
      count_r  <= count_next_s;
      valid_r  <= (count_next_s != '0);
      head_r   <= head_next_s;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_s && !clear) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  assign rdata = head_r;
  assign valid = valid_r;
  assign count = count_r;

endmodule

// File: rtl/vsr_fetch.sv
// Display-file fetcher for one video plane: burst requests, VSR alignment,
// reload flush and pixel FIFO. Optional VSR_FETCH_STATS_EN adds underflow_count.
module vsr_fetch
  import video_pkg::*;
#(
  parameter int unsigned unit_index = 0,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [21:0] address,
  output logic        as,
  input  logic [15:0] din,
  input  logic        burstdata_valid,
  input  logic        bus_ack,
  input  logic        reload_vsr,
  input  logic [21:0] vsr,
  input  logic        fetch_enable,
  input  logic        pixel_rd,
  output logic [15:0] pixel_data,
  output logic        pixel_valid,
  output logic        underflow
`ifdef VSR_FETCH_STATS_EN
  ,
  output logic [15:0] underflow_count
`endif
);

  localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic        UNIT_LSB = 1'(unit_index % 2);

  vsr_fetch_state_e state_r, state_next_s;
  logic [18:0]      fetch_ptr_r;
  logic [1:0]       skip_r;
  logic [1:0]       beat_r;
  logic [CW-1:0]    reserved_r;
  logic [CW-1:0]    reserved_next_s;
  logic             discard_r;
  video_addr_t      address_r;
  logic             as_r;
  logic             underflow_r;

  logic             room_s;
  logic             issue_s;
  logic             last_beat_s;
  logic             done_s;
  logic             push_s;
  logic             pop_ok_s;
  logic [15:0]      fifo_data_s;
  logic             fifo_valid_s;
  logic [CW-1:0]    fifo_count_s;
  logic             unused_s;

  assign unused_s = ^{vsr[0], UNIT_LSB};

  always_comb begin
    state_next_s = state_r;
    issue_s      = 1'b0;
    last_beat_s  = 1'b0;
    done_s       = 1'b0;
    room_s       = ({1'b0, reserved_r} + (CW+1)'(VIDEO_BURST_WORDS)) <= (CW+1)'(FIFO_DEPTH);
    case (state_r)
      ST_IDLE: begin
        if (!reload_vsr && fetch_enable && room_s) begin
          issue_s      = 1'b1;
          state_next_s = ST_BURST;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (burstdata_valid && (beat_r == 2'd3)) begin
          last_beat_s = 1'b1;
          if (bus_ack) begin
            done_s       = 1'b1;
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_WAIT_ACK;
          end
        end else begin
          state_next_s = ST_BURST;
        end
      end
      ST_WAIT_ACK: begin
        if (bus_ack) begin
          done_s       = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT_ACK;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Reservation covers buffered words plus beats still owed by the bus, so a beat always has room.
  always_comb begin
    push_s   = (state_r == ST_BURST) && burstdata_valid && !discard_r && !reload_vsr
               && (beat_r >= skip_r);
    pop_ok_s = pixel_rd && (fifo_count_s != '0);
    if (reload_vsr) begin
      reserved_next_s = '0;
    end else begin
      reserved_next_s = reserved_r
                        + (issue_s ? (CW'(VIDEO_BURST_WORDS) - CW'(skip_r)) : '0)
                        - CW'(pop_ok_s);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      fetch_ptr_r <= '0;
      skip_r      <= '0;
      beat_r      <= '0;
      reserved_r  <= '0;
      discard_r   <= 1'b0;
      address_r   <= '0;
      as_r        <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      reserved_r  <= reserved_next_s;
      underflow_r <= pixel_rd && !fifo_valid_s;

      if (issue_s) begin
        beat_r <= 2'd0;
      end else if ((state_r == ST_BURST) && burstdata_valid) begin
        beat_r <= beat_r + 2'd1;
      end

      if (issue_s) begin
        address_r <= burst_addr(fetch_ptr_r);
        as_r      <= 1'b1;
      end else if (done_s) begin
        as_r <= 1'b0;
      end

      if (reload_vsr) begin
        fetch_ptr_r <= vsr[21:3];
      end else if (issue_s) begin
        fetch_ptr_r <= fetch_ptr_r + 19'd1;
      end

      if (reload_vsr) begin
        skip_r <= vsr[2:1];
      end else if (last_beat_s) begin
        skip_r <= 2'd0;
      end

      // A bus burst cannot be aborted; once reloaded, its leftover beats are simply dropped.
      if (done_s) begin
        discard_r <= 1'b0;
      end else if (reload_vsr && (state_r != ST_IDLE)) begin
        discard_r <= 1'b1;
      end
    end
  end

`ifdef VSR_FETCH_STATS_EN
  logic [15:0] underflow_count_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underflow_count_r <= 16'd0;
    end else if (reload_vsr) begin
      underflow_count_r <= 16'd0;
    end else if (pixel_rd && !fifo_valid_s && (underflow_count_r != 16'hFFFF)) begin
      underflow_count_r <= underflow_count_r + 16'd1;
    end
  end

  assign underflow_count = underflow_count_r;
`endif

  sync_fifo_fwft #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (reload_vsr),
    .push    (push_s),
    .wdata   (din),
    .pop     (pixel_rd),
    .rdata   (fifo_data_s),
    .valid   (fifo_valid_s),
    .count   (fifo_count_s)
  );

  assign address     = address_r;
  assign as          = as_r;
  assign pixel_data  = fifo_data_s;
  assign pixel_valid = fifo_valid_s;
  assign underflow   = underflow_r;

endmodule

// File: tb/tb_vsr_fetch.sv
// Bench for vsr_fetch: a memory-backed bus responder plus a stream model that
// expects consecutive memory words from each VSR and consecutive burst addresses.
module tb_vsr_fetch;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [21:0] address;
  logic        as;
  logic [15:0] din = 16'd0;
  logic        burstdata_valid = 1'b0;
  logic        bus_ack = 1'b0;
  logic        reload_vsr = 1'b0;
  logic [21:0] vsr = 22'd0;
  logic        fetch_enable = 1'b0;
  logic        pixel_rd = 1'b0;
  logic [15:0] pixel_data;
  logic        pixel_valid;
  logic        underflow;
`ifdef VSR_FETCH_STATS_EN
  logic [15:0] underflow_count;
`endif

  int          n_checks = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  logic [21:0] exp_word;
  logic [21:0] exp_burst;
  int          n_bursts;
  logic [21:0] burst_q[$];

  bit          resp_random = 1'b0;
  bit          resp_busy = 1'b0;
  int          resp_beats = 0;
  int          ack_wait = 0;
  logic [21:0] resp_addr = 22'd0;

  vsr_fetch #(.unit_index(0), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .address         (address),
    .as              (as),
    .din             (din),
    .burstdata_valid (burstdata_valid),
    .bus_ack         (bus_ack),
    .reload_vsr      (reload_vsr),
    .vsr             (vsr),
    .fetch_enable    (fetch_enable),
    .pixel_rd        (pixel_rd),
    .pixel_data      (pixel_data),
    .pixel_valid     (pixel_valid),
    .underflow       (underflow)
`ifdef VSR_FETCH_STATS_EN
    ,
    .underflow_count (underflow_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [21:0] a);
    return a[16:1] ^ {11'h000, a[21:17]} ^ 16'h5AC3;
  endfunction

  // Words kept when a VSR lands mid-burst: the first burst is short, later ones full.
  function automatic int fill_for(input int skip);
    return (4 - skip) + 4 * ((DEPTH - (4 - skip)) / 4);
  endfunction

  // Bus slave: serves 4 beats from memory, then acks with or after the last beat.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      burstdata_valid = 1'b0;
      bus_ack = 1'b0;
      if (!resp_busy && as) begin
        resp_busy = 1'b1;
        resp_addr = address;
        resp_beats = 0;
        burst_q.push_back(address);
      end
      if (resp_busy) begin
        if (resp_beats == 4) begin
          if (ack_wait == 0) begin
            bus_ack = 1'b1;
            resp_busy = 1'b0;
          end else begin
            ack_wait--;
          end
        end else if (!resp_random || $urandom_range(0, 3) != 0) begin
          din = mem_word(resp_addr + 22'(2 * resp_beats));
          burstdata_valid = 1'b1;
          resp_beats++;
          if (resp_beats == 4) begin
            ack_wait = resp_random ? int'($urandom_range(0, 3)) : 2;
            if (ack_wait == 0) begin
              bus_ack = 1'b1;
              resp_busy = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    logic [21:0] a;
    @(posedge clk);
    #2;
    while (burst_q.size() > 0) begin
      a = burst_q.pop_front();
      check("burst_addr", 32'(a), 32'(exp_burst));
      exp_burst = exp_burst + 22'd8;
      n_bursts++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reload(input logic [21:0] v);
    vsr = v;
    reload_vsr = 1'b1;
    exp_word = v & 22'h3FFFFE;
    exp_burst = v & 22'h3FFFF8;
    n_bursts = 0;
    tick();
    reload_vsr = 1'b0;
    check("reload_flush", 32'(pixel_valid), 32'd0);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((as || resp_busy) && k < 300) begin
      tick();
      k++;
    end
    check("idle_timeout", 32'(k < 300), 32'd1);
  endtask

  task automatic drain(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (!pixel_valid) break;
      check("drain_data", 32'(pixel_data), 32'(mem_word(exp_word)));
      exp_word = exp_word + 22'd2;
      pixel_rd = 1'b1;
      n++;
      tick();
    end
    pixel_rd = 1'b0;
  endtask

  initial begin
    int n;
    int k;
    exp_word = 22'd0;
    exp_burst = 22'd0;
    n_bursts = 0;

    // Reset values
    run(3);
    check("rst_address", 32'(address), 32'd0);
    check("rst_as", 32'(as), 32'd0);
    check("rst_pixel_data", 32'(pixel_data), 32'd0);
    check("rst_pixel_valid", 32'(pixel_valid), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    reset_n = 1'b1;
    run(2);
    check("idle_no_request", 32'(as), 32'd0);

    // Aligned VSR, no pops: four bursts fill the FIFO exactly
    fetch_enable = 1'b1;
    do_reload(22'h001000);
    run(80);
    check("n_bursts_1000", 32'(n_bursts), 32'd4);
    check("stopped_1000", 32'(as), 32'd0);
    check("full_valid", 32'(pixel_valid), 32'd1);
    fetch_enable = 1'b0;
    drain(n);
    check("fill_1000", 32'(n), 32'(fill_for(0)));

    // Underflow on empty FIFO; head word holds
    check("hold_data", 32'(pixel_data), 32'(mem_word(exp_word - 22'd2)));
    pixel_rd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("underflow_pulse", 32'(underflow), 32'd1);
    end
    pixel_rd = 1'b0;
    tick();
    check("underflow_end", 32'(underflow), 32'd0);
    check("hold_data_after", 32'(pixel_data), 32'(mem_word(exp_word - 22'd2)));
`ifdef VSR_FETCH_STATS_EN
    check("underflow_count", 32'(underflow_count), 32'd5);
`endif

    // Unaligned VSR: leading words of the first burst dropped
    fetch_enable = 1'b1;
    do_reload(22'h001004);
    run(80);
    check("n_bursts_1004", 32'(n_bursts), 32'd4);
    check("skip_head", 32'(pixel_data), 32'(mem_word(22'h001004)));
    fetch_enable = 1'b0;
    drain(n);
    check("fill_1004", 32'(n), 32'(fill_for(2)));

    // Reload in the middle of a burst
    fetch_enable = 1'b1;
    do_reload(22'h001000);
    k = 0;
    while (!(resp_busy && resp_beats == 2) && k < 100) begin
      tick();
      k++;
    end
    check("beat2_timeout", 32'(k < 100), 32'd1);
    tick();
    do_reload(22'h002000);
    check("as_held", 32'(as), 32'd1);
    k = 0;
    while (as && k < 20) begin
      check("flush_empty", 32'(pixel_valid), 32'd0);
      tick();
      k++;
    end
    check("ack_timeout", 32'(k < 20), 32'd1);
    run(80);
    fetch_enable = 1'b0;
    wait_idle();
    check("n_bursts_2000", 32'(n_bursts), 32'd4);
    drain(n);
    check("fill_2000", 32'(n), 32'(fill_for(0)));

    // Pops while full and refilling: order kept, no overflow
    fetch_enable = 1'b1;
    do_reload(22'h004000);
    run(80);
    for (int i = 0; i < 60; i++) begin
      if (pixel_valid) begin
        check("stream_data", 32'(pixel_data), 32'(mem_word(exp_word)));
        exp_word = exp_word + 22'd2;
        pixel_rd = 1'b1;
      end else begin
        pixel_rd = 1'b0;
      end
      tick();
    end
    pixel_rd = 1'b0;
    run(80);
    fetch_enable = 1'b0;
    wait_idle();
    drain(n);
    check("refill_range", 32'(n >= DEPTH - 3 && n <= DEPTH), 32'd1);

    // Address wrap at the top of the 22-bit space
    fetch_enable = 1'b1;
    do_reload(22'h3FFFF8);
    run(80);
    fetch_enable = 1'b0;
    wait_idle();
    check("n_bursts_wrap", 32'(n_bursts), 32'd4);
    drain(n);
    check("fill_wrap", 32'(n), 32'(fill_for(0)));

    // Random VSRs, bus timing, enables and pops
    resp_random = 1'b1;
    fetch_enable = 1'b1;
    do_reload(22'h008000);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        pixel_rd = 1'b0;
        do_reload(22'($urandom) & 22'h3FFFFE);
      end else begin
        if ($urandom_range(0, 49) == 0) fetch_enable = ~fetch_enable;
        if (pixel_valid && $urandom_range(0, 2) != 0) begin
          check("rand_data", 32'(pixel_data), 32'(mem_word(exp_word)));
          exp_word = exp_word + 22'd2;
          pixel_rd = 1'b1;
        end else begin
          pixel_rd = 1'b0;
        end
        tick();
        check("rand_no_underflow", 32'(underflow), 32'd0);
      end
    end
    pixel_rd = 1'b0;
    fetch_enable = 1'b0;
    wait_idle();
    drain(n);
    resp_random = 1'b0;

    // Asynchronous reset in the middle of a burst
    fetch_enable = 1'b1;
    do_reload(22'h005000);
    k = 0;
    while (!(resp_busy && resp_beats == 1) && k < 100) begin
      tick();
      k++;
    end
    check("beat1_timeout", 32'(k < 100), 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_as_drop", 32'(as), 32'd0);
    check("async_address", 32'(address), 32'd0);
    check("async_valid", 32'(pixel_valid), 32'd0);
    fetch_enable = 1'b0;
    tick();
    reset_n = 1'b1;
    k = 0;
    while (resp_busy && k < 50) begin
      tick();
      k++;
    end
    check("stale_timeout", 32'(k < 50), 32'd1);
    run(3);
    check("stale_ignored", 32'(pixel_valid), 32'd0);
    check("post_reset_as", 32'(as), 32'd0);
    check("post_reset_underflow", 32'(underflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
